rotl_engine: RTL and testbench
==============================

ROTL_ENGINE -- requirements
Module: rotl_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter AMT_W, default 5: rotate-amount width; must equal log2(WIDTH).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: engine can accept a request.
REQ-007 SHALL have port in_data, input, WIDTH: word to rotate.
REQ-008 SHALL have port in_amt, input, AMT_W: rotate amount, 0..WIDTH-1.
REQ-009 SHALL have port in_dir, input, 1: 0 = rotate left (inverse of rotr), 1 = rotate right.
REQ-010 SHALL have port out_valid, output, 1: result held on out_data.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port out_data, output, WIDTH: rotated word.
REQ-013 SHALL have port busy, output, 1: high in BUSY or DONE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-015 SHALL drive in_ready high only in IDLE.
REQ-016 Accept SHALL occur in a cycle N where in_valid and in_ready are both high; it SHALL capture in_data, in_amt and in_dir.
REQ-017 On accept with in_amt == 0, SHALL go to DONE with out_data = in_data.
REQ-018 On accept with in_amt != 0, SHALL go to BUSY with count = in_amt.
REQ-019 Each BUSY cycle SHALL rotate the data register by 1 bit in the captured direction and decrement count.
REQ-020 When count == 1 in BUSY, SHALL go to DONE on the same edge.
REQ-021 out_valid SHALL be high exactly in DONE, first in cycle N+1+amt (latency amt+1; amt=0 gives latency 1).
REQ-022 In DONE, out_data SHALL be stable until the handshake.
REQ-023 In DONE, out_valid && out_ready SHALL return the FSM to IDLE on that edge; in_ready SHALL rise the next cycle (no same-cycle re-accept).
REQ-024 In DONE with out_ready low, SHALL hold indefinitely.
REQ-025 Changes on in_* while in BUSY or DONE SHALL be ignored.
REQ-026 The result SHALL equal rotl(in_data, amt) for dir=0 and rotr(in_data, amt) for dir=1, modulo WIDTH.
REQ-027 The rotate amount SHALL never exceed WIDTH-1, since AMT_W bits bound it.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 When rst is high on a clock edge, SHALL enter IDLE, with out_valid=0, out_data=0, busy=0, internal count=0 and in_ready=1 from the next cycle.
REQ-030 Reset SHALL take priority over any accept or handshake in the same cycle.
REQ-031 Reset during BUSY or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-032 Macro ROTL_ENGINE_FAST_EN, when defined, SHALL replace the iterative path with a single-cycle barrel rotate. Every accept goes directly to DONE with the full rotated result, latency 1 for any amount, and BUSY is unreachable.
REQ-033 Without ROTL_ENGINE_FAST_EN, the iterative 1-bit-per-cycle behaviour of REQ-018 to REQ-021 SHALL apply.
REQ-034 Handshake and reset behaviour SHALL be identical in both builds.

Verification
REQ-035 in_data=0x00400000, amt=10, dir=0 -> out_data=0x00000001; out_valid high in cycle N+11 (N+1 in the FAST build).
REQ-036 in_data=0x00000001, amt=10, dir=1 -> out_data=0x00400000; then feed that result back with dir=0 -> 0x00000001 (round trip).
REQ-037 in_data=0xDEADBEEF, amt=0 -> out_data=0xDEADBEEF at N+1; in_data=0x00000001, amt=31, dir=0 -> 0x80000000 at N+32.
REQ-038 Hold out_ready low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a new in_valid is not accepted; raise out_ready -> IDLE next cycle.
REQ-039 Assert rst in mid-BUSY (amt=20, cycle N+7) -> next cycle out_valid=0, out_data=0, busy=0, and in_ready=1 the cycle after.
REQ-040 Back-to-back requests with out_ready tied high -> each result correct, with exactly one idle cycle between the DONE handshake and the next accept.

Source files
------------

// File: rtl/rotl_engine.sv
// Rotate engine: rotates a word left or right by in_amt bits, one bit per cycle.
// Define ROTL_ENGINE_FAST_EN to swap the iterative path for a single-cycle barrel rotate.
module rotl_engine #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             out_valid_q, busy_q, in_ready_q;

`ifdef ROTL_ENGINE_FAST_EN
  logic [WIDTH-1:0] rot_d;

  // Bit i of rotl takes source bit (i - amt) mod WIDTH; rotr takes (i + amt) mod WIDTH.
  always_comb begin
    rot_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_dir)
        rot_d[i] = in_data[(i + int'(in_amt)) % WIDTH];
      else
        rot_d[i] = in_data[(i + WIDTH - int'(in_amt)) % WIDTH];
    end
  end
`else
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic [WIDTH-1:0] step_d;

  assign step_d = dir_q ? {data_q[0], data_q[WIDTH-1:1]}
                        : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifndef ROTL_ENGINE_FAST_EN
      cnt_q       <= '0;
      dir_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          busy_q     <= 1'b1;
          in_ready_q <= 1'b0;
`ifdef ROTL_ENGINE_FAST_EN
          data_q      <= rot_d;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
`else
          data_q <= in_data;
          dir_q  <= in_dir;
          if (in_amt == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= BUSY;
            cnt_q   <= in_amt;
          end
`endif
        end
`ifndef ROTL_ENGINE_FAST_EN
        BUSY: begin
          data_q <= step_d;
          cnt_q  <= cnt_q - AMT_W'(1);
          // The last rotate step and the move to DONE share an edge.
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
`endif
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rotl_engine.sv
// Directed, table-driven bench for rotl_engine plus hand sequences for hold and reset.
module tb_rotl_engine;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_dir, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        dir;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[12];

  rotl_engine #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] a);
`ifdef ROTL_ENGINE_FAST_EN
    return 1;
`else
    return int'(a) + 1;
`endif
  endfunction

  // Entered and left at a negedge inside an IDLE cycle.
  task automatic run_vec(input logic [31:0] d, input logic [4:0] a, input logic dir,
                         input logic [31:0] e, output logic [31:0] res);
    int n;
    logic rdy_seen;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = ~d; in_amt = ~a; in_dir = ~dir;
    @(negedge clk);
    n = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat(a)));
    chk("out_data", out_data, e);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("in_ready_low_while_busy", 32'(rdy_seen), 32'd0);
    res = out_data;
    @(negedge clk);
    chk("idle_after_handshake_in_ready", 32'(in_ready), 32'd1);
    chk("idle_after_handshake_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    vecs[0]  = '{32'h00400000, 5'd10, 1'b0, 32'h00000001};
    vecs[1]  = '{32'h00000001, 5'd10, 1'b1, 32'h00400000};
    vecs[2]  = '{32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF};
    vecs[3]  = '{32'h00000001, 5'd31, 1'b0, 32'h80000000};
    vecs[4]  = '{32'h80000000, 5'd1,  1'b0, 32'h00000001};
    vecs[5]  = '{32'h00000001, 5'd1,  1'b1, 32'h80000000};
    vecs[6]  = '{32'h12345678, 5'd4,  1'b0, 32'h23456781};
    vecs[7]  = '{32'h12345678, 5'd8,  1'b1, 32'h78123456};
    vecs[8]  = '{32'hDEADBEEF, 5'd16, 1'b1, 32'hBEEFDEAD};
    vecs[9]  = '{32'hF0000000, 5'd31, 1'b1, 32'hE0000001};
    vecs[10] = '{32'hA5A5A5A5, 5'd3,  1'b0, 32'h2D2D2D2D};
    vecs[11] = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table with out_ready tied high.
    for (int i = 0; i < 12; i++)
      run_vec(vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].e, r);

    // Round trip: rotr then feed the result back through rotl.
    run_vec(32'h00000001, 5'd10, 1'b1, 32'h00400000, r);
    run_vec(r, 5'd10, 1'b0, 32'h00000001, r);

    // Hold in DONE with out_ready low while a new request is offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000001; in_amt = 5'd2; in_dir = 1'b0;
    @(posedge clk);
    #1 in_data = 32'hCAFEF00D; in_amt = 5'd7;
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
    end
    chk("hold_enter_done", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", out_data, 32'h00000004);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);

    // Reset in cycle N+7 of an amt=20 operation aborts it.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000001; in_amt = 5'd20; in_dir = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    begin
      logic seen = 1'b0;
      repeat (25) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      chk("abort_no_result", 32'(seen), 32'd0);
    end

    // Reset wins over a simultaneous accept.
    in_valid = 1'b1; in_data = 32'h00000010; in_amt = 5'd3; rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_in_ready", 32'(in_ready), 32'd1);
    chk("rst_prio_out_data", out_data, 32'd0);

    run_vec(32'h00000010, 5'd3, 1'b1, 32'h00000002, r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
